// File: rtl/instruction_sequencer.sv
// Fetch/decode front end for the 4-bit computational unit: holds PC and IR,
// decodes the registered instruction into datapath controls and executes jumps.
module instruction_sequencer #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic [7:0]      pm_data,
    input  logic            r_eq_0,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic [3:0]      nibble_ir,
    output logic            NOPC8,
    output logic            NOPCF,
    output logic            NOPD8,
    output logic            NOPDF,
    output logic            jump_taken
);

    localparam int unsigned PAGE_W = PC_W - 4;

    localparam logic [3:0] SRC_PM   = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;
    localparam logic [3:0] SRC_IDLE = 4'd10;

    localparam logic [2:0] DST_O  = 3'd4;
    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;

    localparam logic [8:0] EN_R = 9'h010;
    localparam logic [8:0] EN_O = 9'h100;

    logic              ir_valid;
    logic [PAGE_W-1:0] ir_page;

    logic [2:0] ld_dst;
    logic [2:0] mv_dst;
    logic [2:0] mv_src;
    logic       alu_nop;

    assign pm_addr = pc;

    assign ld_dst = ir[6:4];
    assign mv_dst = ir[5:3];
    assign mv_src = ir[2:0];

    // ALU no-ops are the y=1 encodings with function 0 or 7 (C8, CF, D8, DF).
    assign alu_nop = ir[3] && ((ir[2:0] == 3'd0) || (ir[2:0] == 3'd7));

    // Destination code to write-enable bit; code 4 addresses the output register.
    function automatic logic [8:0] dst_en(input logic [2:0] d);
        if (d == DST_O) begin
            return EN_O;
        end
        return 9'd1 << d;
    endfunction

    // Decode of the registered instruction, masked during reset and bubbles.
    always_comb begin
        source_sel = SRC_IDLE;
        reg_en     = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        NOPC8      = 1'b0;
        NOPCF      = 1'b0;
        NOPD8      = 1'b0;
        NOPDF      = 1'b0;
        jump_taken = 1'b0;
        nibble_ir  = ir[3:0];

        if (!sync_reset && ir_valid) begin
            casez (ir)
                8'b0???_????: begin
                    source_sel = SRC_PM;
                    reg_en     = dst_en(ld_dst);
                    if (ld_dst == DST_DM) begin
                        reg_en[6] = 1'b1;
                        i_sel     = 1'b1;
                    end
                end
                8'b10??_????: begin
                    source_sel = (mv_src == mv_dst) ? SRC_PINS : {1'b0, mv_src};
                    reg_en     = dst_en(mv_dst);
                    // Any dm access post-increments i, unless i itself is the target.
                    if ((mv_src == DST_DM) || (mv_dst == DST_DM)) begin
                        reg_en[6] = 1'b1;
                        i_sel     = (mv_dst != DST_I);
                    end
                end
                8'b110?_????: begin
                    x_sel  = ir[4];
                    y_sel  = ir[3];
                    reg_en = alu_nop ? 9'h000 : EN_R;
                    NOPC8  = (ir == 8'hC8);
                    NOPCF  = (ir == 8'hCF);
                    NOPD8  = (ir == 8'hD8);
                    NOPDF  = (ir == 8'hDF);
                end
                8'b1110_????: begin
                    jump_taken = 1'b1;
                end
                8'b1111_????: begin
                    jump_taken = !r_eq_0;
                end
                default: begin
                    source_sel = SRC_IDLE;
                end
            endcase
        end
    end

    // Fetch pipeline; a taken jump redirects within the jump's own page and squashes the fetched word.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc       <= '0;
            ir       <= 8'h00;
            ir_page  <= '0;
            ir_valid <= 1'b0;
        end else begin
            ir      <= pm_data;
            ir_page <= pc[PC_W-1:4];
            if (jump_taken) begin
                pc       <= {ir_page, ir[3:0]};
                ir_valid <= 1'b0;
            end else begin
                pc       <= pc + PC_W'(1);
                ir_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer: an instruction-level model predicts
// each cycle's outputs into a queue, and a negedge monitor compares them.
module tb_instruction_sequencer;

    localparam int unsigned PC_W = 8;
    localparam int unsigned DMAP [8] = '{0, 1, 2, 3, 8, 5, 6, 7};

    logic            clk = 1'b0;
    logic            sync_reset;
    logic [7:0]      pm_data;
    logic            r_eq_0;
    logic [PC_W-1:0] pm_addr;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [3:0]      source_sel;
    logic [8:0]      reg_en;
    logic            i_sel, x_sel, y_sel;
    logic [3:0]      nibble_ir;
    logic            nopc8, nopcf, nopd8, nopdf;
    logic            jump_taken;

    logic [7:0] pm [256];

    always #5 clk = ~clk;

    assign pm_data = pm[pm_addr];

    instruction_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data), .r_eq_0(r_eq_0),
        .pm_addr(pm_addr), .pc(pc), .ir(ir), .source_sel(source_sel), .reg_en(reg_en),
        .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .nibble_ir(nibble_ir),
        .NOPC8(nopc8), .NOPCF(nopcf), .NOPD8(nopd8), .NOPDF(nopdf),
        .jump_taken(jump_taken)
    );

    typedef struct packed {
        logic       known;
        logic       exec;
        logic [7:0] pc;
        logic [7:0] ir;
        logic [3:0] src;
        logic [8:0] en;
        logic       isel;
        logic       xsel;
        logic       ysel;
        logic [3:0] nops;
        logic       jt;
    } exp_t;

    exp_t q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Instruction-level model: address of the instruction due this cycle, or a bubble.
    logic       m_known  = 1'b0;
    logic       m_bubble = 1'b1;
    logic [7:0] m_addr   = 8'h00;

    function automatic exp_t idle_outputs();
        exp_t e;
        e     = '0;
        e.src = 4'd10;
        return e;
    endfunction

    function automatic logic is_taken(input logic [7:0] op, input logic z);
        return (op[7:4] == 4'hE) || ((op[7:4] == 4'hF) && !z);
    endfunction

    // Instruction semantics straight from the ISA table.
    function automatic exp_t decode(input logic [7:0] op, input logic z);
        exp_t       e;
        logic [2:0] d, s;
        e = idle_outputs();
        if (!op[7]) begin
            d = op[6:4];
            e.src = 4'd8;
            e.en[DMAP[d]] = 1'b1;
            if (d == 3'd7) begin
                e.en[6] = 1'b1;
                e.isel  = 1'b1;
            end
        end else if (op[7:6] == 2'b10) begin
            d = op[5:3];
            s = op[2:0];
            e.src = (s == d) ? 4'd9 : {1'b0, s};
            e.en[DMAP[d]] = 1'b1;
            if (s == 3'd7 || d == 3'd7) begin
                e.en[6] = 1'b1;
                e.isel  = (d != 3'd6);
            end
        end else if (op[7:5] == 3'b110) begin
            e.xsel = op[4];
            e.ysel = op[3];
            e.nops = {op == 8'hC8, op == 8'hCF, op == 8'hD8, op == 8'hDF};
            e.en[4] = (e.nops == 4'b0000);
        end else begin
            e.jt = is_taken(op, z);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input logic rst, input logic z);
        exp_t       e;
        logic [7:0] op;
        sync_reset = rst;
        r_eq_0     = z;
        op         = pm[m_addr];
        if (m_known && !m_bubble && !rst) begin
            e = decode(op, z);
        end else begin
            e = idle_outputs();
        end
        e.known = m_known;
        e.exec  = m_known && !m_bubble;
        e.pc    = m_bubble ? m_addr : m_addr + 8'd1;
        e.ir    = op;
        q.push_back(e);

        if (rst) begin
            m_known  = 1'b1;
            m_bubble = 1'b1;
            m_addr   = 8'h00;
        end else if (!m_known) begin
            m_known = 1'b0;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (is_taken(op, z)) begin
            m_bubble = 1'b1;
            m_addr   = {m_addr[7:4], op[3:0]};
        end else begin
            m_addr = m_addr + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.known) begin
                chk("pc", 32'(pc), 32'(e.pc));
                chk("pm_addr", 32'(pm_addr), 32'(e.pc));
            end
            if (e.exec) begin
                chk("ir", 32'(ir), 32'(e.ir));
                chk("nibble_ir", 32'(nibble_ir), 32'(e.ir[3:0]));
            end
            chk("source_sel", 32'(source_sel), 32'(e.src));
            chk("reg_en", 32'(reg_en), 32'(e.en));
            chk("sel_bits", 32'({i_sel, x_sel, y_sel}), 32'({e.isel, e.xsel, e.ysel}));
            chk("nops", 32'({nopc8, nopcf, nopd8, nopdf}), 32'(e.nops));
            chk("jump_taken", 32'(jump_taken), 32'(e.jt));
        end
    end

    initial begin
        logic rst_done;
        logic no_jumps;
        logic [7:0] op;
        sync_reset = 1'b1;
        r_eq_0     = 1'b0;
        for (int i = 0; i < 256; i++) pm[i] = 8'(i) & 8'h7F;
        pm[8'h00] = 8'h05; pm[8'h01] = 8'hB9; pm[8'h02] = 8'h92; pm[8'h03] = 8'hD2;
        pm[8'h04] = 8'hC8; pm[8'h05] = 8'hCF; pm[8'h06] = 8'hD8; pm[8'h07] = 8'hDF;
        pm[8'h08] = 8'hC7; pm[8'h09] = 8'hC0; pm[8'h0A] = 8'hA7; pm[8'h0B] = 8'hB6;
        pm[8'h0C] = 8'hB7; pm[8'h0D] = 8'hBF; pm[8'h0E] = 8'h7A; pm[8'h0F] = 8'h8B;
        pm[8'h23] = 8'hE7; pm[8'h40] = 8'hF4; pm[8'h47] = 8'hE0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Directed program with one reset landing on an executing LOAD.
        rst_done = 1'b0;
        for (int c = 0; c < 160; c++) begin
            logic r;
            r = !rst_done && c > 90 && m_known && !m_bubble && !pm[m_addr][7];
            if (r) rst_done = 1'b1;
            step(r, 1'($urandom_range(0, 1)));
        end
        chk("mid_run_reset_hit", 32'(rst_done), 32'd1);

        // Random programs; round 0 has no jumps so pc wraps 0xFF -> 0x00.
        for (int rnd = 0; rnd < 6; rnd++) begin
            step(1'b1, 1'b0);
            no_jumps = (rnd == 0);
            for (int i = 0; i < 256; i++) begin
                op = 8'($urandom);
                if (no_jumps && op[7:5] == 3'b111) op[5] = 1'b0;
                pm[i] = op;
            end
            if (!no_jumps) begin
                pm[8'h03] = 8'hF3;
                pm[8'h11] = 8'hE1;
            end
            for (int c = 0; c < 400; c++) begin
                step(!no_jumps && ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
